// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for the 5-stage pipeline.
// Covers load-use bubbles, redirect flushes, multi-cycle EX waits with a
// timeout, and data-memory wait states. All stall/flush outputs are
// combinational; only the multi-cycle tracker is registered.
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_lu/perf_flush/perf_stall.
//
// Multi-cycle contract: mc_req_EX stays high while the op sits in EX.
// mc_done is a 1-cycle pulse. The op leaves EX at the edge that ends the
// mc_done cycle, or the abort cycle on timeout.
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             memread_EX,
    input  logic [4:0]       rd_EX,
    input  logic             redirect_EX,
    input  logic             mc_req_EX,
    input  logic             mc_done,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ack,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             mc_abort,
    output logic             timeout_err,
    output logic             dbg_mc_state,
    output logic [CNT_W-1:0] dbg_mc_cnt
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      perf_lu,
    output logic [31:0]      perf_flush,
    output logic [31:0]      perf_stall
`endif
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    logic [0:0]       mc_state, next_state;
    logic [CNT_W-1:0] mc_cnt, next_cnt;
    logic             memwait, mcwait, lu_haz;
    logic             timeout_hit, abort_hit;

    // Hazard terms. A timeout releases the stall in the same cycle, like mc_done.
    always_comb begin
        memwait     = dmem_req_MEM & ~dmem_ack;
        timeout_hit = (mc_state == ST_MC_WAIT) & ~mc_done &
                      (mc_cnt == CNT_W'(MC_TIMEOUT - 1));
        abort_hit   = timeout_hit & ~memwait;
        mcwait      = ((mc_state == ST_RUN) & mc_req_EX) |
                      ((mc_state == ST_MC_WAIT) & ~mc_done & ~timeout_hit);
        lu_haz      = memread_EX & (rd_EX != 5'd0) &
                      ((use_rs1_ID & (rs1_ID == rd_EX)) |
                       (use_rs2_ID & (rs2_ID == rd_EX)));
    end

    // Prioritised stall/flush decode; everything is forced low during reset.
    always_comb begin
        stall_IF   = 1'b0;
        stall_ID   = 1'b0;
        stall_EX   = 1'b0;
        stall_MEM  = 1'b0;
        flush_IFID = 1'b0;
        flush_IDEX = 1'b0;
        mc_abort   = 1'b0;
        if (!reset) begin
            mc_abort = abort_hit;
            if (memwait) begin
                // Whole pipe frozen; redirect and load-use wait for the ack.
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                stall_EX  = 1'b1;
                stall_MEM = 1'b1;
            end else if (mcwait) begin
                // EX/MEM keeps flowing; downstream valid logic makes the bubble.
                stall_IF = 1'b1;
                stall_ID = 1'b1;
                stall_EX = 1'b1;
            end else if (redirect_EX) begin
                // Wrong-path instructions in IF/ID and ID: load-use is moot.
                flush_IFID = 1'b1;
                flush_IDEX = 1'b1;
            end else if (lu_haz) begin
                stall_IF   = 1'b1;
                stall_ID   = 1'b1;
                flush_IDEX = 1'b1;
            end
        end
    end

    // Multi-cycle tracker next state; a memory wait freezes state and counter.
    always_comb begin
        next_state = mc_state;
        next_cnt   = mc_cnt;
        if (!memwait) begin
            case (mc_state)
                ST_RUN: begin
                    if (mc_req_EX) begin
                        next_state = ST_MC_WAIT;
                        next_cnt   = CNT_W'(1);
                    end
                end
                ST_MC_WAIT: begin
                    if (mc_done || timeout_hit) begin
                        next_state = ST_RUN;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = mc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Tracker registers and the sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_state    <= ST_RUN;
            mc_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            mc_state <= next_state;
            mc_cnt   <= next_cnt;
            if (abort_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // State visibility for checkers.
    always_comb begin
        dbg_mc_state = mc_state[0];
        dbg_mc_cnt   = mc_cnt;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu    <= '0;
            perf_flush <= '0;
            perf_stall <= '0;
        end else begin
            if (flush_IDEX && !flush_IFID) begin
                perf_lu <= perf_lu + 32'd1;
            end
            if (flush_IFID) begin
                perf_flush <= perf_flush + 32'd1;
            end
            if (stall_IF) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with MC_TIMEOUT=8.
// Inputs change on the falling edge and outputs are checked 1 ns later.
// The output vector packs {stall_IF,stall_ID,stall_EX,stall_MEM,flush_IFID,flush_IDEX,mc_abort}.
module tb_hazard_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100010;
    localparam logic [6:0] O_RDIR  = 7'b0000110;
    localparam logic [6:0] O_MC    = 7'b1110000;
    localparam logic [6:0] O_MEM   = 7'b1111000;
    localparam logic [6:0] O_ABORT = 7'b0000001;

    logic             clk, reset;
    logic [4:0]       rs1_ID, rs2_ID, rd_EX;
    logic             use_rs1_ID, use_rs2_ID, memread_EX, redirect_EX;
    logic             mc_req_EX, mc_done, dmem_req_MEM, dmem_ack;
    logic             stall_IF, stall_ID, stall_EX, stall_MEM;
    logic             flush_IFID, flush_IDEX, mc_abort, timeout_err;
    logic             dbg_mc_state;
    logic [CNT_W-1:0] dbg_mc_cnt;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      perf_lu, perf_flush, perf_stall;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    hazard_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .memread_EX(memread_EX), .rd_EX(rd_EX),
        .redirect_EX(redirect_EX), .mc_req_EX(mc_req_EX), .mc_done(mc_done),
        .dmem_req_MEM(dmem_req_MEM), .dmem_ack(dmem_ack),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .stall_MEM(stall_MEM), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .mc_abort(mc_abort), .timeout_err(timeout_err),
        .dbg_mc_state(dbg_mc_state), .dbg_mc_cnt(dbg_mc_cnt)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_lu(perf_lu), .perf_flush(perf_flush), .perf_stall(perf_stall)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] outs();
        return {stall_IF, stall_ID, stall_EX, stall_MEM, flush_IFID, flush_IDEX, mc_abort};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; memread_EX = 1'b0;
        redirect_EX = 1'b0; mc_req_EX = 1'b0; mc_done = 1'b0;
        dmem_req_MEM = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic drive_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                            input logic [4:0] r2, input logic u2);
        memread_EX = 1'b1; rd_EX = rd;
        rs1_ID = r1; use_rs1_ID = u1;
        rs2_ID = r2; use_rs2_ID = u2;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        // Reset with hazards present on the inputs
        reset = 1'b1;
        drive_idle();
        drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        mc_req_EX = 1'b1;
        dmem_req_MEM = 1'b1;
        #3;
        check("rst_outs", 32'(outs()), 32'(O_NONE));
        check("rst_state", 32'(dbg_mc_state), 32'd0);
        check("rst_cnt", 32'(dbg_mc_cnt), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        drive_idle();
        reset = 1'b0;
        #1 check("post_rst_outs", 32'(outs()), 32'(O_NONE));

        // Load-use on rs1: one bubble, then clear
        next_cycle(); drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1 check("lu_rs1", 32'(outs()), 32'(O_LU));
        next_cycle();
        #1 check("lu_clear", 32'(outs()), 32'(O_NONE));
        next_cycle(); drive_lu(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);
        #1 check("lu_rs2", 32'(outs()), 32'(O_LU));
        next_cycle(); drive_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
        #1 check("lu_unused", 32'(outs()), 32'(O_NONE));
        next_cycle(); drive_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); memread_EX = 1'b0;
        #1 check("lu_noload", 32'(outs()), 32'(O_NONE));

        // x0 never hazards; redirect beats load-use
        next_cycle(); drive_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 check("lu_x0", 32'(outs()), 32'(O_NONE));
        next_cycle(); drive_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); redirect_EX = 1'b1;
        #1 check("redirect_lu", 32'(outs()), 32'(O_RDIR));

        // Multi-cycle op with mc_done in the 6th cycle (5 stall cycles)
        for (int i = 0; i < 5; i++) exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        for (int c = 0; c < 6; c++) begin
            next_cycle(); mc_req_EX = 1'b1; mc_done = (c == 5);
            #1;
            check("mc_stall_EX", 32'(stall_EX), exp_q.pop_front());
            check("mc_cnt", 32'(dbg_mc_cnt), 32'(c));
            check("mc_state", 32'(dbg_mc_state), (c == 0) ? 32'd0 : 32'd1);
        end
        // Back-to-back op re-enters the wait
        next_cycle(); mc_req_EX = 1'b1;
        #1 check("b2b_state", 32'(dbg_mc_state), 32'd0);
        check("b2b_outs", 32'(outs()), 32'(O_MC));
        next_cycle(); mc_req_EX = 1'b1; mc_done = 1'b1;
        #1 check("b2b_wait", 32'(dbg_mc_state), 32'd1);
        check("b2b_done_outs", 32'(outs()), 32'(O_NONE));
        // mc_done while running is ignored
        next_cycle(); mc_done = 1'b1;
        #1 check("done_in_run_outs", 32'(outs()), 32'(O_NONE));
        check("done_in_run_state", 32'(dbg_mc_state), 32'd0);

        // Timeout: 7 stall cycles, abort in the 8th, stall released there
        for (int c = 0; c < 8; c++) begin
            next_cycle(); mc_req_EX = 1'b1;
            #1;
            check("to_cnt", 32'(dbg_mc_cnt), 32'(c));
            check("to_outs", 32'(outs()), (c < 7) ? 32'(O_MC) : 32'(O_ABORT));
            check("to_terr_pre", 32'(timeout_err), 32'd0);
        end
        next_cycle();
        #1 check("to_after_state", 32'(dbg_mc_state), 32'd0);
        check("to_after_cnt", 32'(dbg_mc_cnt), 32'd0);
        check("to_after_outs", 32'(outs()), 32'(O_NONE));
        check("to_terr", 32'(timeout_err), 32'd1);

        // mc_done coinciding with the timeout cycle wins, no abort
        for (int c = 0; c < 8; c++) begin
            next_cycle(); mc_req_EX = 1'b1; mc_done = (c == 7);
            #1;
            if (c == 7) check("done_vs_to_outs", 32'(outs()), 32'(O_NONE));
        end
        next_cycle();
        #1 check("done_vs_to_state", 32'(dbg_mc_state), 32'd0);
        check("terr_sticky", 32'(timeout_err), 32'd1);

        // Memory wait during MC_WAIT freezes the counter and defers redirect
        next_cycle(); mc_req_EX = 1'b1;
        next_cycle(); mc_req_EX = 1'b1;
        #1 check("mw_pre_cnt", 32'(dbg_mc_cnt), 32'd1);
        for (int c = 0; c < 3; c++) begin
            next_cycle(); mc_req_EX = 1'b1; dmem_req_MEM = 1'b1; redirect_EX = (c == 0);
            #1;
            check("mw_outs", 32'(outs()), 32'(O_MEM));
            check("mw_cnt", 32'(dbg_mc_cnt), 32'd2);
        end
        next_cycle(); mc_req_EX = 1'b1; dmem_req_MEM = 1'b1; dmem_ack = 1'b1;
        #1 check("mw_ack_outs", 32'(outs()), 32'(O_MC));
        check("mw_ack_cnt", 32'(dbg_mc_cnt), 32'd2);
        next_cycle(); mc_req_EX = 1'b1; mc_done = 1'b1;
        #1 check("mw_resume_cnt", 32'(dbg_mc_cnt), 32'd3);
        check("mw_done_outs", 32'(outs()), 32'(O_NONE));

        // Asynchronous reset in the middle of a wait
        next_cycle(); mc_req_EX = 1'b1;
        next_cycle(); mc_req_EX = 1'b1;
        next_cycle(); mc_req_EX = 1'b1;
        #1 check("ar_pre_cnt", 32'(dbg_mc_cnt), 32'd2);
        #1 reset = 1'b1;
        #1 check("ar_outs", 32'(outs()), 32'(O_NONE));
        check("ar_state", 32'(dbg_mc_state), 32'd0);
        check("ar_cnt", 32'(dbg_mc_cnt), 32'd0);
        check("ar_terr", 32'(timeout_err), 32'd0);
        next_cycle(); reset = 1'b0;
        #1 check("ar_rel_state", 32'(dbg_mc_state), 32'd0);
        check("ar_rel_cnt", 32'(dbg_mc_cnt), 32'd0);
        check("ar_rel_outs", 32'(outs()), 32'(O_NONE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
